// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and error codes for matrix entry.
package matrix_pkg;

  localparam int MAX_DIM = 5;
  localparam int ADDR_W  = 5;
  localparam int DIM_W   = 3;
  localparam int ERR_W   = 3;

  localparam logic [ERR_W-1:0] ERR_NONE    = 3'b000;
  localparam logic [ERR_W-1:0] ERR_DIM     = 3'b001;
  localparam logic [ERR_W-1:0] ERR_VAL     = 3'b011;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'b100;
  localparam logic [ERR_W-1:0] ERR_OVERRUN = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_M    = 3'd1,
    GET_N    = 3'd2,
    GET_ELEM = 3'd3,
    WRITE    = 3'd4,
    FINISH   = 3'd5
  } state_t;

  // A dimension is legal when it lies in 1..MAX_DIM.
  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_entry_ctrl_if.sv
// Write port into the matrix store.
// Handshake: the master raises wr_en with wr_slot/wr_addr/wr_data and holds all
// of them stable until a cycle where wr_ready is also high; that cycle is the
// transfer. wr_ready may be high without wr_en and means nothing then.
interface matrix_entry_ctrl_if
  import matrix_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic              wr_en;
  logic              wr_ready;
  logic [SLOT_W-1:0] wr_slot;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, wr_slot, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_en, wr_slot, wr_addr, wr_data, output wr_ready);

endinterface

// File: rtl/rx_timeout_counter.sv
// Counts idle cycles between received bytes; pulses expired on the cycle the
// count reaches TIMEOUT_CYC-1.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expired = enable && !clear && (cnt_inc == CNT_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter; a clear or an expiry restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || clear || expired) cnt_q <= '0;
    else if (enable)             cnt_q <= cnt_inc;
  end

endmodule

// File: rtl/matrix_entry_ctrl.sv
// Parses m, n and m*n elements from the UART byte stream, range-checks them
// and writes them into a round-robin slot of the matrix store.
module matrix_entry_ctrl
  import matrix_pkg::*;
#(
  parameter  int DATA_W      = 4,
  parameter  int NUM_SLOTS   = 4,
  parameter  int TIMEOUT_CYC = 50_000_000,
  localparam int SLOT_W      = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          uart_rx_data,
  input  logic                rx_done,
  input  logic [DATA_W-1:0]   val_min,
  input  logic [DATA_W-1:0]   val_max,
  input  logic                start,
  output logic                busy,
  matrix_entry_ctrl_if.master wr,
  output logic                input_done,
  output logic [ERR_W-1:0]    error_type,
  output logic [SLOT_W-1:0]   done_slot,
  output logic [DIM_W-1:0]    done_m,
  output logic [DIM_W-1:0]    done_n,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output state_t              dbg_state
);

  state_t state_q, state_d;

  logic [3:0]        m_q, n_q;
  logic [DIM_W-1:0]  row_q, col_q;
  logic [3:0]        pend_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [SLOT_W-1:0] next_slot_q;
  logic [ERR_W-1:0]  err_q;

  logic [3:0]        rx_nib, elem_nib;
  logic [DATA_W-1:0] elem_val;
  logic [ADDR_W-1:0] elem_addr;
  logic              tmo_expired, tmo_clear, tmo_enable;
  logic              take_m, take_n, hdr_ok, load_elem, pend_set, pend_clr;
  logic              accept, last_elem, set_err;
  logic [ERR_W-1:0]  err_d;
  logic              unused_rx_hi;

  assign rx_nib       = uart_rx_data[3:0];
  assign unused_rx_hi = ^uart_rx_data[7:4];
  // A buffered byte takes precedence over a byte arriving this cycle.
  assign elem_nib     = pend_valid_q ? pend_q : rx_nib;
  assign elem_val     = DATA_W'(elem_nib);
  assign elem_addr    = ADDR_W'(row_q) * ADDR_W'(MAX_DIM) + ADDR_W'(col_q);
  assign last_elem    = (4'(row_q) + 4'd1 == m_q) && (4'(col_q) + 4'd1 == n_q);

  assign tmo_clear  = rx_done || (state_q == IDLE && start);
  assign tmo_enable = (state_q == GET_M) || (state_q == GET_N) || (state_q == GET_ELEM);

  rx_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_d   = state_q;
    take_m    = 1'b0;
    take_n    = 1'b0;
    hdr_ok    = 1'b0;
    load_elem = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    accept    = 1'b0;
    set_err   = 1'b0;
    err_d     = ERR_NONE;
    case (state_q)
      IDLE: if (start) state_d = GET_M;
      GET_M: begin
        if (rx_done) begin
          take_m  = 1'b1;
          state_d = GET_N;
        end else if (tmo_expired) begin
          set_err = 1'b1; err_d = ERR_TIMEOUT; state_d = FINISH;
        end
      end
      GET_N: begin
        if (rx_done) begin
          take_n = 1'b1;
          if (dim_ok(m_q) && dim_ok(rx_nib)) begin
            hdr_ok  = 1'b1;
            state_d = GET_ELEM;
          end else begin
            set_err = 1'b1; err_d = ERR_DIM; state_d = FINISH;
          end
        end else if (tmo_expired) begin
          set_err = 1'b1; err_d = ERR_TIMEOUT; state_d = FINISH;
        end
      end
      GET_ELEM: begin
        if (pend_valid_q || rx_done) begin
          pend_clr = pend_valid_q;
          pend_set = pend_valid_q && rx_done;
          if (elem_val < val_min || elem_val > val_max) begin
            set_err = 1'b1; err_d = ERR_VAL; state_d = FINISH;
          end else begin
            load_elem = 1'b1;
            state_d   = WRITE;
          end
        end else if (tmo_expired) begin
          set_err = 1'b1; err_d = ERR_TIMEOUT; state_d = FINISH;
        end
      end
      WRITE: begin
        if (wr.wr_ready) begin
          accept  = 1'b1;
          state_d = last_elem ? FINISH : GET_ELEM;
        end
        // Bytes arriving while a write waits go to the one-byte buffer.
        if (rx_done && !(wr.wr_ready && last_elem)) begin
          if (pend_valid_q) begin
            set_err = 1'b1; err_d = ERR_OVERRUN; state_d = FINISH;
          end else begin
            pend_set = 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Header, element, slot bookkeeping and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0; n_q <= '0; row_q <= '0; col_q <= '0;
      pend_q <= '0; pend_valid_q <= 1'b0;
      wr_addr_q <= '0; wr_data_q <= '0;
      next_slot_q <= '0; err_q <= ERR_NONE;
      done_slot <= '0; done_m <= '0; done_n <= '0;
      slot_valid <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        err_q        <= ERR_NONE;
        pend_valid_q <= 1'b0;
      end
      if (take_m) m_q <= rx_nib;
      if (take_n) n_q <= rx_nib;
      if (hdr_ok) begin
        slot_valid[next_slot_q] <= 1'b0;
        row_q <= '0;
        col_q <= '0;
      end
      if (load_elem) begin
        wr_data_q <= elem_val;
        wr_addr_q <= elem_addr;
      end
      if (pend_set) begin
        pend_q       <= rx_nib;
        pend_valid_q <= 1'b1;
      end else if (pend_clr) begin
        pend_valid_q <= 1'b0;
      end
      if (accept && !last_elem) begin
        if (4'(col_q) + 4'd1 == n_q) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
      if (set_err) err_q <= err_d;
      if (state_q == FINISH && err_q == ERR_NONE) begin
        slot_valid[next_slot_q] <= 1'b1;
        done_slot   <= next_slot_q;
        done_m      <= m_q[DIM_W-1:0];
        done_n      <= n_q[DIM_W-1:0];
        next_slot_q <= next_slot_q + SLOT_W'(1);
      end
    end
  end

  assign busy       = (state_q == GET_M) || (state_q == GET_N) ||
                      (state_q == GET_ELEM) || (state_q == WRITE);
  assign input_done = (state_q == FINISH);
  assign error_type = err_q;
  assign dbg_state  = state_q;

  assign wr.wr_en   = (state_q == WRITE);
  assign wr.wr_slot = next_slot_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Directed bench for matrix_entry_ctrl with a write/done scoreboard.
module tb_matrix_entry_ctrl;
  import matrix_pkg::*;

  localparam int W = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_rx_data = '0;
  logic        rx_done = 1'b0;
  logic [3:0]  val_min = 4'd0;
  logic [3:0]  val_max = 4'd9;
  logic        start = 1'b0;
  logic        busy, input_done;
  logic [2:0]  error_type;
  logic [1:0]  done_slot;
  logic [2:0]  done_m, done_n;
  logic [3:0]  slot_valid;
  state_t      dbg_state;

  matrix_entry_ctrl_if #(.DATA_W(4), .NUM_SLOTS(4)) wr_bus ();

  matrix_entry_ctrl #(.DATA_W(4), .NUM_SLOTS(4), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .uart_rx_data(uart_rx_data), .rx_done(rx_done),
    .val_min(val_min), .val_max(val_max), .start(start), .busy(busy),
    .wr(wr_bus.master), .input_done(input_done), .error_type(error_type),
    .done_slot(done_slot), .done_m(done_m), .done_n(done_n),
    .slot_valid(slot_valid), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   done_q[$];
  logic [W-1:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void push_wr(input int slot, input int addr, input int data);
    exp_q.push_back({2'(slot), 5'(addr), 4'(data)});
  endfunction

  // Scoreboard: compare each accepted write and each completion.
  always @(negedge clk) begin
    if (wr_bus.wr_en && wr_bus.wr_ready) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(wr_bus.wr_en), 0);
      else begin
        exp_w = exp_q.pop_front();
        check("write", {wr_bus.wr_slot, wr_bus.wr_addr, wr_bus.wr_data}, 32'(exp_w));
        check("addr_bound", 32'(wr_bus.wr_addr <= 5'd24), 1);
      end
    end
    if (input_done) begin
      if (done_q.size() == 0) check("unexpected_done", 32'(input_done), 0);
      else begin
        check("error_type", 32'(error_type), 32'(done_q.pop_front()));
        check("busy_at_done", 32'(busy), 0);
      end
    end
  end

  // Driver tasks; the main thread always sits 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    tick(2);
  endtask

  task automatic start_entry();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done_all();
    int budget = 200;
    while (done_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check("done_pending", done_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_wr_en"}, 32'(wr_bus.wr_en), 0);
    check({tag, "_input_done"}, 32'(input_done), 0);
    check({tag, "_error_type"}, 32'(error_type), 0);
    check({tag, "_slot_valid"}, 32'(slot_valid), 0);
    check({tag, "_done"}, {done_slot, done_m, done_n}, 0);
    check({tag, "_wr_bus"}, {wr_bus.wr_slot, wr_bus.wr_addr, wr_bus.wr_data}, 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int cyc;
    int done_cnt;
    wr_bus.wr_ready = 1'b1;

    // Reset state.
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // 2x3 matrix into slot 0.
    val_min = 4'd0; val_max = 4'd9;
    push_wr(0, 0, 1); push_wr(0, 1, 2); push_wr(0, 2, 3);
    push_wr(0, 5, 4); push_wr(0, 6, 5); push_wr(0, 7, 6);
    done_q.push_back(ERR_NONE);
    start_entry();
    send_byte(8'h02); send_byte(8'h03);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    wait_done_all();
    tick(2);
    check("ok_done_m", 32'(done_m), 2);
    check("ok_done_n", 32'(done_n), 3);
    check("ok_done_slot", 32'(done_slot), 0);
    check("ok_slot_valid", 32'(slot_valid), 32'h1);

    // Bad dimension (m=6); upper nibble must be ignored.
    done_q.push_back(ERR_DIM);
    start_entry();
    send_byte(8'hA6); send_byte(8'h02);
    wait_done_all();
    tick(1);
    check("dim_slot_valid", 32'(slot_valid), 32'h1);
    check("dim_done_m", 32'(done_m), 2);

    // Element out of range after one accepted element.
    val_min = 4'd2; val_max = 4'd7;
    push_wr(1, 0, 3);
    done_q.push_back(ERR_VAL);
    start_entry();
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h09);
    wait_done_all();
    tick(1);
    check("val_slot_valid", 32'(slot_valid), 32'h1);
    check("val_error_held", 32'(error_type), 32'(ERR_VAL));

    // Stalled store: one byte buffered, then an overrun.
    val_min = 4'd0; val_max = 4'd9;
    push_wr(1, 0, 1); push_wr(1, 1, 2);
    done_q.push_back(ERR_OVERRUN);
    start_entry();
    send_byte(8'h02); send_byte(8'h02);
    wr_bus.wr_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {wr_bus.wr_en, wr_bus.wr_slot, wr_bus.wr_addr, wr_bus.wr_data},
            {1'b1, 2'd1, 5'd0, 4'd1});
      tick(1);
    end
    wr_bus.wr_ready = 1'b1;
    tick(4);
    wr_bus.wr_ready = 1'b0;
    send_byte(8'h03);
    check("stall_addr5", {wr_bus.wr_en, wr_bus.wr_addr}, {1'b1, 5'd5});
    send_byte(8'h04);
    send_byte(8'h05);
    wait_done_all();
    wr_bus.wr_ready = 1'b1;
    tick(1);
    check("ovr_slot_valid", 32'(slot_valid), 32'h1);

    // Timeout after m only.
    done_q.push_back(ERR_TIMEOUT);
    start_entry();
    uart_rx_data = 8'h03;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    cyc = 1;
    while (!input_done && cyc < 60) begin
      tick(1);
      cyc++;
    end
    check("timeout_latency", cyc, 20);
    wait_done_all();
    tick(1);
    check("tmo_error_held", 32'(error_type), 32'(ERR_TIMEOUT));

    // Round-robin slot allocation from a fresh reset.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      push_wr(k % 4, 0, k + 1);
      done_q.push_back(ERR_NONE);
      start_entry();
      send_byte(8'h01); send_byte(8'h01);
      send_byte(8'(k + 1));
      wait_done_all();
      tick(2);
      check("rr_done_slot", 32'(done_slot), 32'(k % 4));
      check("rr_done_dims", {done_m, done_n}, {3'd1, 3'd1});
    end
    check("rr_slot_valid", 32'(slot_valid), 32'hF);

    // Reset in the middle of an entry.
    start_entry();
    send_byte(8'h02); send_byte(8'h02);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (input_done) done_cnt++;
      tick(1);
    end
    check("no_done_after_reset", done_cnt, 0);
    check("writes_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
